// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Byte-stream input, instruction-memory write port and
//                processor-control signals of the program loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              proc_enable;
    logic              proc_restart;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   load_count;

    // Host / byte source side.
    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, proc_enable, proc_restart,
               busy, err, load_count
    );

    // Loader side.
    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, proc_enable, proc_restart,
               busy, err, load_count
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Serial program loader. Receives a length byte N followed by
//                N big-endian 16-bit words, writes them to instruction memory
//                from address 0, then restarts and enables the processor.
//                Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing
//                XOR checksum byte over the length and all data bytes).
//  Revision    : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5,
        ST_CKSUM = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              proc_enable_q, proc_enable_d;
    logic              proc_restart_q, proc_restart_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        acc_q, acc_d;
`endif

    logic accept;
    logic len_bad;
    logic last_word;
    logic loading_d;

    // A byte transfers only when the source offers it and we advertise ready.
    assign accept    = bus.in_valid && in_ready_q;
    assign len_bad   = (bus.in_data == 8'd0) || (32'(bus.in_data) > 32'(DEPTH));
    assign last_word = ((32'(load_count_q) + 32'd1) == 32'(len_q));

    // Next-state and next-output computation; all outputs are registered
    // from the next state so they line up exactly with the state register.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        hi_d           = hi_q;
        load_count_d   = load_count_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        acc_d          = acc_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    state_d      = ST_LEN;
                    load_count_d = '0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    acc_d = bus.in_data;
`endif
                    state_d = len_bad ? ST_ERROR : ST_HI;
                end
            end
            ST_HI: begin
                if (accept) begin
                    hi_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    acc_d = acc_q ^ bus.in_data;
`endif
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = load_count_q[ADDR_W-1:0];
                    wr_data_d = {hi_q, bus.in_data};
`ifdef LOADER_CHECKSUM_EN
                    acc_d = acc_q ^ bus.in_data;
`endif
                    // Saturate rather than wrap: the count never exceeds DEPTH.
                    if (32'(load_count_q) < 32'(DEPTH)) begin
                        load_count_d = load_count_q + (ADDR_W+1)'(1);
                    end
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == acc_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        loading_d = (state_d == ST_LEN) || (state_d == ST_HI) || (state_d == ST_LO)
`ifdef LOADER_CHECKSUM_EN
                    || (state_d == ST_CKSUM)
`endif
                    ;
        in_ready_d     = loading_d;
        busy_d         = loading_d;
        err_d          = (state_d == ST_ERROR);
        // Restart fires on the DONE entry edge; enable follows one cycle later
        // and drops on the same edge that leaves DONE.
        proc_restart_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        proc_enable_d  = (state_d == ST_DONE) && (state_q == ST_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            hi_q           <= '0;
            load_count_q   <= '0;
            in_ready_q     <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            proc_enable_q  <= 1'b0;
            proc_restart_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            hi_q           <= hi_d;
            load_count_q   <= load_count_d;
            in_ready_q     <= in_ready_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            proc_enable_q  <= proc_enable_d;
            proc_restart_q <= proc_restart_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
`ifdef LOADER_CHECKSUM_EN
            acc_q          <= acc_d;
`endif
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.proc_enable  = proc_enable_q;
    assign bus.proc_restart = proc_restart_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.load_count   = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader with a stream-level
//                reference model of the expected memory image and outcome.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    // Observed activity, collected away from the active edge.
    int          got_addr[$];
    logic [15:0] got_data[$];
    int          restart_cnt = 0;
    int          wr_in_err   = 0;

    // Reference-model expectations.
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    bit          exp_ok;
    int          exp_count;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got_addr.push_back(int'(bus.wr_addr));
            got_data.push_back(bus.wr_data);
            if (bus.err !== 1'b0) wr_in_err++;
        end
        if (bus.proc_restart === 1'b1) restart_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: N words go to addresses 0..N-1; invalid N yields an error with
    // no writes; with the checksum option the final byte must equal the XOR
    // of every preceding byte of the stream.
    task automatic model_load(input bq_t s);
        int n;
        exp_addr.delete();
        exp_data.delete();
        exp_ok    = 1'b0;
        exp_count = 0;
        n = int'(s[0]);
        if (n == 0 || n > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back({s[1 + 2*i], s[2 + 2*i]});
        end
        exp_count = n;
        exp_ok    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i <= 2*n; i++) x ^= s[i];
            exp_ok = (s[2*n + 1] == x);
        end
`endif
    endtask

    task automatic build_stream(input int n, output bq_t s);
        s.delete();
        s.push_back(8'(n));
        for (int i = 0; i < 2*n; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (s[i]) x ^= s[i];
            s.push_back(x);
        end
`endif
    endtask

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        restart_cnt = 0;
        wr_in_err   = 0;
    endtask

    // Called and returns at a falling edge.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offers one byte after `gap` idle cycles; returns at the falling edge
    // after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (budget >= 64) begin
            bad++;
            $display("FAIL send_byte: in_ready=%b never rose within 64 cycles for byte %02h", bus.in_ready, b);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input bq_t s, input int max_gap);
        foreach (s[i]) send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.proc_enable, bus.proc_restart,
             bus.busy, bus.err, bus.load_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d data=%h en=%b rst=%b busy=%b err=%b cnt=%0d required all zero",
                     bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.proc_enable,
                     bus.proc_restart, bus.busy, bus.err, bus.load_count);
        end
        total++;
        if (got_addr.size() != 0 || restart_cnt != 0) begin
            bad++;
            $display("FAIL reset_release: writes=%0d restarts=%0d required 0 and 0", got_addr.size(), restart_cnt);
        end
    endtask

    task automatic test_basic();
        bq_t s;
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD);
`endif
        clear_mon();
        pulse_start();
        total++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: busy=%b in_ready=%b required 1 and 1", bus.busy, bus.in_ready);
        end
        send_stream(s, 0);
        total++;
        if (bus.proc_restart !== 1'b1 || bus.proc_enable !== 1'b0) begin
            bad++;
            $display("FAIL basic_restart_edge: restart=%b enable=%b required 1 and 0", bus.proc_restart, bus.proc_enable);
        end
        repeat (3) @(negedge clk);
        total++;
        if (got_addr.size() != 2) begin
            bad++;
            $display("FAIL basic_write_count: got %0d writes required 2", got_addr.size());
        end else begin
            total++;
            if (got_addr[0] != 0 || got_data[0] !== 16'h1234 || got_addr[1] != 1 || got_data[1] !== 16'hABCD) begin
                bad++;
                $display("FAIL basic_writes: got %0d:%h %0d:%h required 0:1234 1:abcd",
                         got_addr[0], got_data[0], got_addr[1], got_data[1]);
            end
        end
        total++;
        if (restart_cnt != 1 || bus.proc_enable !== 1'b1 || bus.load_count !== 7'd2 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: restarts=%0d enable=%b count=%0d busy=%b required 1 1 2 0",
                     restart_cnt, bus.proc_enable, bus.load_count, bus.busy);
        end
    endtask

    task automatic test_restart_in_done();
        bq_t s;
        build_stream(3, s);
        model_load(s);
        total++;
        if (bus.proc_enable !== 1'b1) begin
            bad++;
            $display("FAIL redo_pre_enable: enable=%b required 1", bus.proc_enable);
        end
        clear_mon();
        pulse_start();
        total++;
        if (bus.proc_enable !== 1'b0 || bus.busy !== 1'b1 || bus.load_count !== '0) begin
            bad++;
            $display("FAIL redo_drop: enable=%b busy=%b count=%0d required 0 1 0",
                     bus.proc_enable, bus.busy, bus.load_count);
        end
        send_stream(s, 1);
        repeat (3) @(negedge clk);
        begin
            int mism;
            mism = -1;
            for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
                if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) mism = i;
            total++;
            if (got_addr.size() != exp_addr.size() || mism != -1) begin
                bad++;
                $display("FAIL redo_writes: got %0d writes (first bad idx %0d) required %0d matching writes",
                         got_addr.size(), mism, exp_addr.size());
            end
        end
        total++;
        if (bus.proc_enable !== 1'b1 || restart_cnt != 1 || int'(bus.load_count) != exp_count) begin
            bad++;
            $display("FAIL redo_done: enable=%b restarts=%0d count=%0d required 1 1 %0d",
                     bus.proc_enable, restart_cnt, bus.load_count, exp_count);
        end
    endtask

    task automatic test_len_errors();
        logic [7:0] lens[3];
        lens[0] = 8'h00;
        lens[1] = 8'h41;
        lens[2] = 8'($urandom_range(65, 255));
        foreach (lens[k]) begin
            clear_mon();
            pulse_start();
            total++;
            if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL lenerr_start_%0d: err=%b in_ready=%b required 0 and 1", k, bus.err, bus.in_ready);
            end
            send_byte(lens[k], 0);
            bus.in_valid = 1'b0;
            repeat (3) @(negedge clk);
            total++;
            if (bus.err !== 1'b1 || bus.proc_enable !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0
                || got_addr.size() != 0 || restart_cnt != 0) begin
                bad++;
                $display("FAIL lenerr_%02h: err=%b enable=%b busy=%b rdy=%b writes=%0d restarts=%0d required 1 0 0 0 0 0",
                         lens[k], bus.err, bus.proc_enable, bus.busy, bus.in_ready, got_addr.size(), restart_cnt);
            end
        end
    endtask

    task automatic test_reset_midload();
        bq_t s;
        build_stream(4, s);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(s[i], 0);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.proc_enable, bus.proc_restart,
             bus.busy, bus.err, bus.load_count} !== '0) begin
            bad++;
            $display("FAIL midreset_async: rdy=%b we=%b addr=%0d data=%h en=%b rst=%b busy=%b err=%b cnt=%0d required all zero",
                     bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.proc_enable,
                     bus.proc_restart, bus.busy, bus.err, bus.load_count);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || got_addr.size() != 0 || restart_cnt != 0) begin
            bad++;
            $display("FAIL midreset_idle: busy=%b writes=%0d restarts=%0d required 0 0 0",
                     bus.busy, got_addr.size(), restart_cnt);
        end
        build_stream(2, s);
        model_load(s);
        pulse_start();
        send_stream(s, 0);
        repeat (3) @(negedge clk);
        total++;
        if (got_addr.size() != 2 || got_addr[0] != 0 || got_data[0] !== exp_data[0]
            || got_addr[1] != 1 || got_data[1] !== exp_data[1]) begin
            bad++;
            $display("FAIL midreset_reload: got %0d writes required 2 starting at address 0 with data %h %h",
                     got_addr.size(), exp_data[0], exp_data[1]);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bq_t s;
        s = '{8'h01, 8'h12, 8'h34, 8'h27};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        repeat (3) @(negedge clk);
        total++;
        if (bus.proc_enable !== 1'b1 || bus.err !== 1'b0 || restart_cnt != 1
            || got_addr.size() != 1 || got_data[0] !== 16'h1234) begin
            bad++;
            $display("FAIL cksum_good: enable=%b err=%b restarts=%0d writes=%0d required 1 0 1 1",
                     bus.proc_enable, bus.err, restart_cnt, got_addr.size());
        end
        s = '{8'h01, 8'h12, 8'h34, 8'h00};
        clear_mon();
        pulse_start();
        send_stream(s, 0);
        repeat (3) @(negedge clk);
        total++;
        if (bus.proc_enable !== 1'b0 || bus.err !== 1'b1 || restart_cnt != 0 || wr_in_err != 0) begin
            bad++;
            $display("FAIL cksum_bad: enable=%b err=%b restarts=%0d wr_in_err=%0d required 0 1 0 0",
                     bus.proc_enable, bus.err, restart_cnt, wr_in_err);
        end
    endtask
`endif

    task automatic test_random_loads();
        bq_t s;
        for (int it = 0; it < 6; it++) begin
            build_stream(int'($urandom_range(1, 16)), s);
`ifdef LOADER_CHECKSUM_EN
            if (it == 3) s[s.size() - 1] = ~s[s.size() - 1];
`endif
            model_load(s);
            clear_mon();
            pulse_start();
            send_stream(s, 2);
            repeat (3) @(negedge clk);
            begin
                int mism;
                mism = -1;
                for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
                    if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) mism = i;
                total++;
                if (got_addr.size() != exp_addr.size() || mism != -1) begin
                    bad++;
                    $display("FAIL rand%0d_writes: got %0d writes (first bad idx %0d) required %0d",
                             it, got_addr.size(), mism, exp_addr.size());
                end
            end
            total++;
            if (bus.proc_enable !== exp_ok || bus.err !== !exp_ok || restart_cnt != int'(exp_ok)
                || int'(bus.load_count) != exp_count || wr_in_err != 0) begin
                bad++;
                $display("FAIL rand%0d_outcome: enable=%b err=%b restarts=%0d count=%0d required %b %b %0d %0d",
                         it, bus.proc_enable, bus.err, restart_cnt, bus.load_count,
                         exp_ok, !exp_ok, int'(exp_ok), exp_count);
            end
        end
    endtask

    task automatic test_full_depth();
        bq_t s;
        build_stream(DEPTH, s);
        model_load(s);
        clear_mon();
        pulse_start();
        send_stream(s, 3);
        repeat (3) @(negedge clk);
        begin
            int mism;
            mism = -1;
            for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
                if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) mism = i;
            total++;
            if (got_addr.size() != DEPTH || mism != -1) begin
                bad++;
                $display("FAIL full_writes: got %0d writes (first bad idx %0d) required %0d", got_addr.size(), mism, DEPTH);
            end
        end
        total++;
        if (got_addr.size() == 0 || got_addr[got_addr.size() - 1] != DEPTH - 1) begin
            bad++;
            $display("FAIL full_last_addr: last address %0d required %0d",
                     (got_addr.size() == 0) ? -1 : got_addr[got_addr.size() - 1], DEPTH - 1);
        end
        total++;
        if (int'(bus.load_count) != DEPTH || bus.proc_enable !== 1'b1 || restart_cnt != 1) begin
            bad++;
            $display("FAIL full_done: count=%0d enable=%b restarts=%0d required %0d 1 1",
                     bus.load_count, bus.proc_enable, restart_cnt, DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart_in_done();
        test_len_errors();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random_loads();
        test_full_depth();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of instruction-memory words.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning instruction-memory address width, with DEPTH = 2^ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a new program load (level sampled each cycle).
REQ-006 SHALL have port in_data  input  8  serial program byte.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W  instruction-memory write address.
REQ-011 SHALL have port wr_data  output  16  instruction word to write.
REQ-012 SHALL have port proc_enable  output  1  drives processor controller_enable.
REQ-013 SHALL have port proc_restart  output  1  one-cycle restart pulse to processor controller.
REQ-014 SHALL have port busy  output  1  high in any load state.
REQ-015 SHALL have port err  output  1  load aborted.
REQ-016 SHALL have port load_count  output  ADDR_W+1  words written in the current/last load.

Function
REQ-017 SHALL implement states IDLE, LEN, HI, LO, CKSUM, DONE, ERROR.
REQ-018 SHALL accept a byte only on a rising edge with in_valid=1 and in_ready=1.
REQ-019 SHALL drive in_ready=1 exactly in LEN, HI, LO, CKSUM.
REQ-020 SHALL go IDLE->LEN, DONE->LEN or ERROR->LEN when start=1, clearing load_count and err in the same edge.
REQ-021 SHALL ignore start in LEN, HI, LO, CKSUM.
REQ-022 SHALL, in LEN, latch accepted byte as N; N=0 or N>DEPTH -> ERROR, else -> HI.
REQ-023 SHALL, in HI, latch accepted byte as high byte and go to LO.
REQ-024 SHALL, in LO, on accept, assert wr_en for exactly the next cycle with wr_addr=load_count[ADDR_W-1:0] and wr_data={high byte, low byte}, then increment load_count.
REQ-025 SHALL, after the Nth word is accepted, leave LO for DONE (or CKSUM per REQ-034); otherwise return to HI.
REQ-026 SHALL, on DONE entry, pulse proc_restart for exactly one cycle and set proc_enable=1 from the following cycle while in DONE.
REQ-027 SHALL drive proc_enable=0 in every state except DONE; leaving DONE drops it on the same edge.
REQ-028 SHALL hold err=1 in ERROR only; wr_en never asserts in ERROR.
REQ-029 SHALL write N=DEPTH words to addresses 0..DEPTH-1 with no wrap-around; load_count saturates at DEPTH.
REQ-030 SHALL tolerate in_valid gaps of any length without state change.

Reset
REQ-031 SHALL, on reset assertion, immediately force state IDLE and in_ready, wr_en, wr_addr, wr_data, proc_enable, proc_restart, busy, err, load_count to 0, including mid-load.
REQ-032 SHALL not write memory or pulse proc_restart in the first cycle after reset release.

Configuration
REQ-033 SHALL use macro LOADER_CHECKSUM_EN to compile the checksum feature in or out.
REQ-034 SHALL, with LOADER_CHECKSUM_EN defined, XOR all accepted bytes from N onward into an 8-bit accumulator, go LO->CKSUM after the Nth word, accept one checksum byte there, and go to DONE if it equals the accumulator, else ERROR.
REQ-035 SHALL, without LOADER_CHECKSUM_EN, omit the accumulator and CKSUM state and go LO->DONE directly.

Verification
REQ-036 SHALL cover: start, bytes 02,12,34,AB,CD -> writes 0:1234, 1:ABCD, proc_restart one pulse, proc_enable=1, load_count=2.
REQ-037 SHALL cover: length byte 00 then 41 (separate runs) -> err=1, no wr_en, proc_enable=0.
REQ-038 SHALL cover: reset asserted after HI byte of word 3 -> all outputs 0 asynchronously, IDLE; restart with start reloads from address 0.
REQ-039 SHALL cover: N=64 with random in_valid gaps -> 64 writes, last address 63, load_count=64, no wrap.
REQ-040 SHALL cover (LOADER_CHECKSUM_EN): 01,12,34 then checksum 27 -> DONE; checksum 00 -> ERROR, proc_enable=0.
REQ-041 SHALL cover: start=1 in DONE -> proc_enable drops on next edge, busy=1, new load begins.
